// File: rtl/branch_resolve_stage_pkg.sv
// Shared types and constants for the execute-stage branch resolver.
package branch_resolve_stage_pkg;

  localparam int XLEN            = 32;
  localparam int IMM_W           = 16;
  localparam int BR_OFFSET_SHIFT = 2;

  typedef enum logic [2:0] {
    BR_BEQ    = 3'd0,
    BR_BNE    = 3'd1,
    BR_BLEZ   = 3'd2,
    BR_BGTZ   = 3'd3,
    BR_BLTZ   = 3'd4,
    BR_BGEZ   = 3'd5,
    BR_ALWAYS = 3'd6,
    BR_NEVER  = 3'd7
  } br_cond_t;

endpackage

// File: rtl/branch_resolve_stage_br_cond_sel.sv
// Branch condition select: maps a condition code and the comparator flags
// (rs==rt, rs>0 signed, rs==0, rs<0 signed) onto the taken decision.
module br_cond_sel
  import branch_resolve_stage_pkg::*;
(
  input  br_cond_t cond,
  input  logic     eq,
  input  logic     gt_s,
  input  logic     rs_zero,
  input  logic     rs_neg,
  output logic     taken
);

  // Pure decode of the condition against the flags; no state.
  always_comb begin
    taken = 1'b0;
    case (cond)
      BR_BEQ:    taken = eq;
      BR_BNE:    taken = !eq;
      BR_BLEZ:   taken = rs_neg || rs_zero;
      BR_BGTZ:   taken = gt_s;
      BR_BLTZ:   taken = rs_neg;
      BR_BGEZ:   taken = !rs_neg;
      BR_ALWAYS: taken = 1'b1;
      BR_NEVER:  taken = 1'b0;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_stage.sv
// Execute-stage branch resolver: S1 holds the registered operands and runs
// the compare/select, S2 holds the resolved result and drives the fetch
// redirect. Optional retire statistics are enabled with BR_STATS_EN.
module branch_resolve_stage #(
  parameter int XLEN = 32
`ifdef BR_STATS_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_cond,
  input  logic [XLEN-1:0] in_rs,
  input  logic [XLEN-1:0] in_rt,
  input  logic [XLEN-1:0] in_pc,
  input  logic [15:0]     in_imm,
  input  logic            in_pred,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic            out_redirect,
  output logic [XLEN-1:0] out_pc
`ifdef BR_STATS_EN
  , output logic [CNT_W-1:0] stat_br
  , output logic [CNT_W-1:0] stat_mis
`endif
);
  import branch_resolve_stage_pkg::*;

  // Sequential fall-through address; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] br_seq_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

  // Branch target: pc + 4 + sign-extended word offset, modulo 2^XLEN.
  function automatic logic [XLEN-1:0] br_target(input logic [XLEN-1:0] pc,
                                                input logic signed [IMM_W-1:0] imm);
    logic signed [XLEN-1:0] off;
    off = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
    off = off <<< BR_OFFSET_SHIFT;
    return br_seq_pc(pc) + $unsigned(off);
  endfunction

  logic                   vld_p1, vld_p2;
  br_cond_t               cond_p1;
  logic signed [XLEN-1:0] rs_p1, rt_p1;
  logic [XLEN-1:0]        pc_p1;
  logic signed [IMM_W-1:0] imm_p1;
  logic                   pred_p1;

  logic                   eq_p1, gt_s_p1, rs_zero_p1, rs_neg_p1, taken_p1;
  logic [XLEN-1:0]        npc_p1;

  logic                   taken_p2, redir_p2;
  logic [XLEN-1:0]        pc_p2;

  logic                   in_fire, s2_load, out_fire;

  // Flush forces acceptance so decode is never stalled by a dying pipe, but
  // nothing presented in that cycle is captured.
  assign in_ready = flush || !vld_p1 || !vld_p2 || out_ready;
  assign in_fire  = in_valid && in_ready && !flush;
  assign s2_load  = vld_p1 && (!vld_p2 || out_ready) && !flush;
  assign out_fire = vld_p2 && out_ready && !flush;

  // Stage valids: flush and reset both empty the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (in_fire)      vld_p1 <= 1'b1;
      else if (s2_load) vld_p1 <= 1'b0;
      if (s2_load)       vld_p2 <= 1'b1;
      else if (out_fire) vld_p2 <= 1'b0;
    end
  end

  // ---- S1: operand capture from decode ----
  // Capture operands on an accepted branch (data path, not reset).
  always_ff @(posedge clk) begin
    if (in_fire) begin
      cond_p1 <= br_cond_t'(in_cond);
      rs_p1   <= in_rs;
      rt_p1   <= in_rt;
      pc_p1   <= in_pc;
      imm_p1  <= in_imm;
      pred_p1 <= in_pred;
    end
  end

  // Comparator flags on the registered operands; signed tests against zero
  // reduce to the sign bit and a zero detect.
  assign eq_p1      = (rs_p1 == rt_p1);
  assign rs_zero_p1 = (rs_p1 == '0);
  assign rs_neg_p1  = rs_p1[XLEN-1];
  assign gt_s_p1    = !rs_neg_p1 && !rs_zero_p1;

  br_cond_sel u_cond_sel (
    .cond    (cond_p1),
    .eq      (eq_p1),
    .gt_s    (gt_s_p1),
    .rs_zero (rs_zero_p1),
    .rs_neg  (rs_neg_p1),
    .taken   (taken_p1)
  );

  assign npc_p1 = taken_p1 ? br_target(pc_p1, imm_p1) : br_seq_pc(pc_p1);

  // ---- S2: resolved result ----
  // Result register; only reloads when S1 advances so outputs hold under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_p2 <= 1'b0;
      redir_p2 <= 1'b0;
      pc_p2    <= '0;
    end else if (s2_load) begin
      taken_p2 <= taken_p1;
      redir_p2 <= taken_p1 ^ pred_p1;
      pc_p2    <= npc_p1;
    end
  end

  assign out_valid    = vld_p2;
  assign out_taken    = taken_p2;
  assign out_pc       = pc_p2;
  assign out_redirect = vld_p2 && redir_p2;

`ifdef BR_STATS_EN
  // Retire counters: advance only on a real (non-flushed) output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br  <= '0;
      stat_mis <= '0;
    end else if (out_fire) begin
      stat_br <= stat_br + CNT_W'(1);
      if (out_redirect) stat_mis <= stat_mis + CNT_W'(1);
    end
  end
`endif

endmodule
